// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between a valid/ready producer and consumer, updated on the
// falling clock edge. in_ready comes only from registered state, so out_ready never reaches it combinationally.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_push;
    logic              w_pop;
    logic              w_main_from_in;
    logic              w_main_from_skid;
    logic              w_skid_from_in;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready    = (r_state != ST_FULL);
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_data    = r_main_data;
    // A bubble must never present live control bits downstream.
    assign out_ctrl    = out_valid ? r_main_ctrl : '0;
    assign occupancy   = r_state;
    assign stall_count = r_stall_cnt;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt    = ST_ONE;
                        w_main_from_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_from_in = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt    = ST_FULL;
                        w_skid_from_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush clears only the control bits; stale payload is harmless once the stage is empty.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_main_from_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_skid_from_in) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based reference model compared every
// rising edge (away from the falling active edge), plus directed literal checks.
module tb_pipe_skid_stage;

    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: held entries in arrival order plus the stall counter.
    logic [DATA_W-1:0] qd[$];
    logic [CTRL_W-1:0] qc[$];
    int                m_stall = 0;
    int                m_n;
    bit                m_push;
    bit                m_pop;

    pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            qd.delete();
            qc.delete();
            m_stall = 0;
        end else begin
            m_n    = qd.size();
            m_push = in_valid && (m_n < 2);
            m_pop  = (m_n > 0) && out_ready;
            if (m_n > 0 && !out_ready && !flush && m_stall < CNT_MAX) m_stall++;
            if (flush) begin
                qd.delete();
                qc.delete();
            end else begin
                if (m_pop) begin
                    void'(qd.pop_front());
                    void'(qc.pop_front());
                end
                if (m_push) begin
                    qd.push_back(in_data);
                    qc.push_back(in_ctrl);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en && !reset) begin
            chk("m_in_ready", 64'(in_ready), 64'(qd.size() < 2));
            chk("m_out_valid", 64'(out_valid), 64'(qd.size() > 0));
            chk("m_occupancy", 64'(occupancy), 64'(qd.size()));
            chk("m_stall_count", 64'(stall_count), 64'(m_stall));
            if (qd.size() > 0) begin
                chk("m_out_data", 64'(out_data), 64'(qd[0]));
                chk("m_out_ctrl", 64'(out_ctrl), 64'(qc[0]));
            end else begin
                chk("m_out_ctrl_bubble", 64'(out_ctrl), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // First push after reset appears one falling edge later.
        out_ready = 1'b1;
        set_in(1'b1, 32'hA5, 16'h0003);
        tick();
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_data", 64'(out_data), 64'hA5);
        chk("first_ctrl", 64'(out_ctrl), 64'h0003);
        chk("first_occ", 64'(occupancy), 64'd1);
        set_in(1'b0, 32'h0, 16'h0);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Back-pressure fills both registers, then drain in order.
        out_ready = 1'b0;
        set_in(1'b1, 32'h11, 16'h0001);
        tick();
        set_in(1'b1, 32'h22, 16'h0002);
        tick();
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_data), 64'h11);
        set_in(1'b0, 32'h0, 16'h0);
        out_ready = 1'b1;
        tick();
        chk("drain_second", 64'(out_data), 64'h22);
        chk("drain_second_v", 64'(out_valid), 64'd1);
        tick();
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk("drained_ctrl", 64'(out_ctrl), 64'd0);

        // Streaming with no back-pressure.
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_in(1'b1, 32'(32'h100 + i), 16'($urandom));
            tick();
            chk("stream_occ", 64'(occupancy), 64'd1);
            chk("stream_data", 64'(out_data), 64'(32'h100 + i));
        end
        chk("stream_stall", 64'(stall_count), 64'd0);
        set_in(1'b0, 32'h0, 16'h0);
        tick();

        // Flush while full with a push attempted.
        out_ready = 1'b0;
        set_in(1'b1, 32'h33, 16'h0033);
        tick();
        set_in(1'b1, 32'h44, 16'h0044);
        tick();
        set_in(1'b1, 32'h99, 16'h0007);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 16'h0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);

        // Entry accepted in the flush cycle is dropped.
        out_ready = 1'b1;
        set_in(1'b1, 32'h55, 16'h0005);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 16'h0);
        chk("flush_accept_occ", 64'(occupancy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_never_emerges", 64'(out_valid), 64'd0);
        end

        // Stall counter saturation, then asynchronous reset between edges.
        pulse_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h77, 16'h0077);
        tick();
        set_in(1'b0, 32'h0, 16'h0);
        repeat (20) tick();
        chk("stall_sat", 64'(stall_count), 64'd15);
        tick();
        chk("stall_hold", 64'(stall_count), 64'd15);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_stall", 64'(stall_count), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_occ", 64'(occupancy), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        tick();
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 4) != 0, $urandom, 16'($urandom));
            out_ready = ((i / 64) % 2 == 0) ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
            flush     = (($urandom % 20) == 0);
            if (($urandom % 250) == 0) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
            tick();
        end
        set_in(1'b0, 32'h0, 16'h0);
        flush = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
